// File: rtl/fetch_unit.sv
// RV32I fetch stage: owns the PC, fetches words over a req/ack port and queues them for decode.
// Optional macro FETCH_MISALIGN_TRAP_EN adds a HALT state for misaligned redirect targets.
`timescale 1ns/1ps

module fetch_unit #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int              DEPTH    = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [XLEN-1:0] imem_rdata,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            inst_valid,
    output logic [XLEN-1:0] inst,
    output logic [XLEN-1:0] inst_pc,
    input  logic            inst_ready,
    output logic            fetch_misalign
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;

    localparam logic [1:0] ST_FETCH = 2'd0;
    localparam logic [1:0] ST_WAIT  = 2'd1;
    localparam logic [1:0] ST_DROP  = 2'd2;
    localparam logic [1:0] ST_HALT  = 2'd3;

    logic [1:0]      state_reg, state_next;
    logic            run_reg;
    logic [XLEN-1:0] fetch_pc_reg, fetch_pc_next;
    logic [XLEN-1:0] drop_addr_reg, drop_addr_next;
    logic [AW-1:0]   wr_ptr_reg, rd_ptr_reg;
    logic [CW-1:0]   count_reg, count_next, count_after;

    logic [XLEN-1:0] buf_data_reg [DEPTH];
    logic [XLEN-1:0] buf_pc_reg   [DEPTH];

    logic ack_hs;
    logic push;
    logic pop;
    logic open_req;
    logic target_misaligned;

    // run_reg holds the request off until the first edge after reset release.
    assign imem_req   = run_reg && (state_reg == ST_FETCH || state_reg == ST_DROP);
    assign imem_addr  = (state_reg == ST_DROP) ? drop_addr_reg : fetch_pc_reg;
    assign inst_valid = (count_reg != '0);
    assign inst       = buf_data_reg[rd_ptr_reg];
    assign inst_pc    = buf_pc_reg[rd_ptr_reg];

    assign ack_hs   = imem_req && imem_ack;
    assign open_req = imem_req && !imem_ack;
    assign push     = ack_hs && (state_reg == ST_FETCH) && !redirect;
    assign pop      = inst_valid && inst_ready && !redirect;

    assign count_after = count_reg + CW'(push) - CW'(pop);

`ifdef FETCH_MISALIGN_TRAP_EN
    assign target_misaligned = (redirect_pc[1:0] != 2'b00);
    assign fetch_misalign    = (state_reg == ST_HALT);
`else
    assign target_misaligned = 1'b0;
    assign fetch_misalign    = 1'b0;
`endif

    always_comb begin
        state_next     = state_reg;
        fetch_pc_next  = fetch_pc_reg;
        drop_addr_next = drop_addr_reg;
        count_next     = redirect ? '0 : count_after;
        if (redirect) begin
            fetch_pc_next = redirect_pc & ~XLEN'(3);
            if (target_misaligned) begin
                state_next = ST_HALT;
            end else if (open_req) begin
                // Keep presenting the in-flight address so memory sees a stable request.
                state_next     = ST_DROP;
                drop_addr_next = imem_addr;
            end else begin
                state_next = ST_FETCH;
            end
        end else begin
            case (state_reg)
                ST_FETCH: begin
                    if (push) begin
                        fetch_pc_next = fetch_pc_reg + XLEN'(4);
                        if (count_after == CW'(DEPTH)) begin
                            state_next = ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (pop) begin
                        state_next = ST_FETCH;
                    end
                end
                ST_DROP: begin
                    if (ack_hs) begin
                        state_next = ST_FETCH;
                    end
                end
                default: begin
                    state_next = state_reg;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ST_FETCH;
            run_reg       <= 1'b0;
            fetch_pc_reg  <= RESET_PC;
            drop_addr_reg <= RESET_PC;
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            count_reg     <= '0;
        end else begin
            state_reg     <= state_next;
            run_reg       <= 1'b1;
            fetch_pc_reg  <= fetch_pc_next;
            drop_addr_reg <= drop_addr_next;
            count_reg     <= count_next;
            if (redirect) begin
                wr_ptr_reg <= '0;
                rd_ptr_reg <= '0;
            end else begin
                if (push) begin
                    wr_ptr_reg <= wr_ptr_reg + AW'(1);
                end
                if (pop) begin
                    rd_ptr_reg <= rd_ptr_reg + AW'(1);
                end
            end
        end
    end

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    buf_data_reg[gi] <= '0;
                    buf_pc_reg[gi]   <= '0;
                end else if (push && (wr_ptr_reg == AW'(gi))) begin
                    buf_data_reg[gi] <= imem_rdata;
                    buf_pc_reg[gi]   <= fetch_pc_reg;
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus random traffic checked
// against a stream-level scoreboard (decode must see contiguous PCs from the last redirect).
`timescale 1ns/1ps

module tb_fetch_unit;

    localparam int          DEPTH    = 2;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_ready = 1'b0;
    logic        fetch_misalign;

    fetch_unit #(.XLEN(32), .RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc), .inst_ready(inst_ready),
        .fetch_misalign(fetch_misalign)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000;
    endfunction

    assign imem_rdata = mem_word(imem_addr);

    int checks = 0;
    int errors = 0;
    int pop_count = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
    } item_t;

    item_t       sb[$];
    item_t       it;
    logic [31:0] model_pc = RESET_PC;
    bit          model_halt = 1'b0;
    bit          prev_pending = 1'b0;
    logic [31:0] prev_addr = '0;

    // Monitor: mid-cycle sampling; every handshake here takes effect at the next rising edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            sb.delete();
            model_pc     = RESET_PC;
            model_halt   = 1'b0;
            prev_pending = 1'b0;
        end else begin
            chk("inst_valid", 32'(inst_valid), 32'(sb.size() != 0));
            chk("addr_align", 32'(imem_addr[1:0]), 32'd0);
`ifndef FETCH_MISALIGN_TRAP_EN
            chk("misalign_tied", 32'(fetch_misalign), 32'd0);
`endif
            if (sb.size() >= DEPTH || model_halt) begin
                chk("req_gated", 32'(imem_req), 32'd0);
            end
            if (prev_pending) begin
                chk("req_hold", 32'(imem_req), 32'd1);
                chk("addr_hold", imem_addr, prev_addr);
            end
            prev_pending = imem_req && !imem_ack;
            prev_addr    = imem_addr;
            if (redirect) begin
                sb.delete();
                model_pc = redirect_pc & ~32'd3;
`ifdef FETCH_MISALIGN_TRAP_EN
                model_halt = (redirect_pc[1:0] != 2'b00);
                if (model_halt) prev_pending = 1'b0;
`endif
            end else begin
                if (inst_valid && inst_ready && sb.size() != 0) begin
                    it = sb.pop_front();
                    pop_count++;
                    $display("pop pc=%h inst=%h", inst_pc, inst);
                    chk("inst_pc", inst_pc, it.pc);
                    chk("inst", inst, it.data);
                end
                if (imem_req && imem_ack && !model_halt && imem_addr == model_pc) begin
                    sb.push_back('{model_pc, mem_word(model_pc)});
                    model_pc = model_pc + 32'd4;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        #1;
        chk("rst_req", 32'(imem_req), 32'd0);
        chk("rst_addr", imem_addr, RESET_PC);
        chk("rst_valid", 32'(inst_valid), 32'd0);
        chk("rst_inst", inst, 32'd0);
        chk("rst_inst_pc", inst_pc, 32'd0);
        chk("rst_misalign", 32'(fetch_misalign), 32'd0);

        // Reset release, ack every cycle, ready high: sequential fetch 0,4,8.
        step(); step();
        rst_n = 1'b1; imem_ack = 1'b1; inst_ready = 1'b1;
        @(negedge clk);
        chk("pre_first_req", 32'(imem_req), 32'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            @(negedge clk);
            chk("seq_req", 32'(imem_req), 32'd1);
            chk("seq_addr", imem_addr, 32'(4 * i));
        end

        // Asynchronous reset mid-transaction.
        step(); #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_req", 32'(imem_req), 32'd0);
        chk("mid_rst_addr", imem_addr, RESET_PC);
        chk("mid_rst_valid", 32'(inst_valid), 32'd0);
        step();
        rst_n = 1'b1; imem_ack = 1'b1; inst_ready = 1'b0;

        // Ready low: buffer fills to DEPTH, then requests stop.
        repeat (6) step();
        @(negedge clk);
        chk("full_req", 32'(imem_req), 32'd0);
        chk("full_valid", 32'(inst_valid), 32'd1);
        chk("full_head_pc", inst_pc, 32'h0);
        step();
        inst_ready = 1'b1; imem_ack = 1'b0;
        @(negedge clk);
        chk("drain_head0", inst_pc, 32'h0);
        step();
        @(negedge clk);
        chk("drain_head1", inst_pc, 32'h4);
        chk("resume_req", 32'(imem_req), 32'd1);
        chk("resume_addr", imem_addr, 32'h8);
        step();
        @(negedge clk);
        chk("drained_valid", 32'(inst_valid), 32'd0);

        // Held request at 0x8, redirect during the stall: old address held, data dropped.
        step();
        redirect = 1'b1; redirect_pc = 32'h100;
        @(negedge clk);
        chk("drop_addr0", imem_addr, 32'h8);
        step();
        redirect = 1'b0;
        @(negedge clk);
        chk("drop_addr1", imem_addr, 32'h8);
        chk("drop_req", 32'(imem_req), 32'd1);
        step();
        imem_ack = 1'b1;
        @(negedge clk);
        chk("drop_addr2", imem_addr, 32'h8);
        step();
        @(negedge clk);
        chk("after_drop_addr", imem_addr, 32'h100);

        // Address wrap at the top of the address space.
        step();
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        step();
        redirect = 1'b0;
        @(negedge clk);
        chk("wrap_addr0", imem_addr, 32'hFFFF_FFFC);
        step();
        @(negedge clk);
        chk("wrap_addr1", imem_addr, 32'h0000_0000);

        // Misaligned redirect target.
        step();
        redirect = 1'b1; redirect_pc = 32'h102;
        step();
        redirect = 1'b0;
        @(negedge clk);
`ifdef FETCH_MISALIGN_TRAP_EN
        chk("halt_flag", 32'(fetch_misalign), 32'd1);
        chk("halt_req", 32'(imem_req), 32'd0);
`else
        chk("misalign_addr", imem_addr, 32'h100);
        chk("misalign_flag", 32'(fetch_misalign), 32'd0);
`endif
        repeat (3) step();
        redirect = 1'b1; redirect_pc = 32'h104;
        step();
        redirect = 1'b0;
        @(negedge clk);
        chk("realign_addr", imem_addr, 32'h104);
        chk("realign_flag", 32'(fetch_misalign), 32'd0);

        // Random traffic against the scoreboard.
        for (int c = 0; c < 3000; c++) begin
            step();
            imem_ack    = ($urandom_range(0, 3) != 0);
            inst_ready  = ($urandom_range(0, 3) != 0);
            redirect    = ($urandom_range(0, 31) == 0);
            redirect_pc = $urandom;
        end

        // Drain at full rate from an aligned target: near one instruction per cycle.
        step();
        redirect = 1'b1; redirect_pc = $urandom & ~32'd3;
        imem_ack = 1'b1; inst_ready = 1'b1;
        step();
        redirect = 1'b0;
        base = pop_count;
        repeat (20) step();
        chk("throughput", 32'((pop_count - base) >= 17), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
